// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: drives the 5-stage pipeline write-enables from hazard, branch and debug requests.
// Optional macro STALL_COUNTER_EN adds a saturating stall-cycle counter on o_stall_count.
`default_nettype none

module pipeline_stall_controller #(
   parameter int NB_CNT       = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_stall,
   input  logic              i_branch_taken,
   input  logic              i_halt_instr,
   input  logic              i_dbg_halt_req,
   input  logic              i_dbg_run,
   input  logic              i_dbg_step,
   output logic              o_pc_we,
   output logic              o_if_id_we,
   output logic              o_if_id_flush,
   output logic              o_id_ex_bubble,
   output logic              o_pipe_we,
   output logic              o_halted,
   output logic              o_step_done,
   output logic [NB_CNT-1:0] o_stall_count
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] drain_q, drain_d;
   logic          step_done_q, step_done_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_HALTED;
         drain_q     <= '0;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         step_done_q <= step_done_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      drain_d        = drain_q;
      step_done_d    = 1'b0;
      o_pc_we        = 1'b0;
      o_if_id_we     = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_bubble = 1'b0;
      o_pipe_we      = 1'b0;
      case (state_q)
         ST_RUN, ST_STEP: begin
            // A taken branch must still advance the PC and load the NOP into IF/ID, even under a stall.
            o_pipe_we      = 1'b1;
            o_pc_we        = ~i_stall | i_branch_taken;
            o_if_id_we     = ~i_stall | i_branch_taken;
            o_if_id_flush  = i_branch_taken;
            o_id_ex_bubble = i_stall;
            if (state_q == ST_STEP) begin
               state_d     = ST_HALTED;
               step_done_d = 1'b1;
            end else if (i_halt_instr || i_dbg_halt_req) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            o_pipe_we     = 1'b1;
            o_if_id_we    = 1'b1;
            o_if_id_flush = 1'b1;
            if (drain_q == '0) begin
               state_d = ST_HALTED;
            end else begin
               drain_d = drain_q - CW'(1);
            end
         end
         default: begin
            if (i_dbg_run) begin
               state_d = ST_RUN;
            end else if (i_dbg_step) begin
               state_d = ST_STEP;
            end
         end
      endcase
   end

   assign o_halted    = (state_q == ST_HALTED);
   assign o_step_done = step_done_q;

`ifdef STALL_COUNTER_EN
   logic [NB_CNT-1:0] cnt_q;
   logic              w_inc;

   assign w_inc = i_stall && ((state_q == ST_RUN) || (state_q == ST_STEP)) && !(&cnt_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (w_inc) begin
         cnt_q <= cnt_q + NB_CNT'(1);
      end
   end

   assign o_stall_count = cnt_q;
`else
   assign o_stall_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus random stimulus against a behavioural model.
`default_nettype none

module tb_pipeline_stall_controller;

   localparam int NB      = 4;
   localparam int D       = 4;
   localparam int CNT_MAX = (1 << NB) - 1;
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_STEP = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic stall, br, hi, hr, run, step;
   logic pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_we, halted, step_done;
   logic [NB-1:0] stall_count;

   always #5 clk = ~clk;

   pipeline_stall_controller #(.NB_CNT(NB), .DRAIN_CYCLES(D)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_branch_taken(br),
      .i_halt_instr(hi), .i_dbg_halt_req(hr), .i_dbg_run(run), .i_dbg_step(step),
      .o_pc_we(pc_we), .o_if_id_we(if_id_we), .o_if_id_flush(if_id_flush),
      .o_id_ex_bubble(id_ex_bubble), .o_pipe_we(pipe_we), .o_halted(halted),
      .o_step_done(step_done), .o_stall_count(stall_count)
   );

   int checks = 0;
   int errors = 0;

   // Model: current mode, drain cycles still to run, pending step-done, stall total.
   int m_mode, m_left, m_sd, m_cnt;
   // Samples of the last compared cycle, for the literal expectations.
   int s_pc, s_ifid, s_flush, s_bub, s_pipe, s_halt, s_sd, s_cnt;

`ifdef STALL_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_HALT; m_left = 0; m_sd = 0; m_cnt = 0;
   endtask

   task automatic cycle(input bit a_s, input bit a_b, input bit a_hi, input bit a_hr,
                        input bit a_run, input bit a_step);
      int e_pc, e_ifid, e_fl, e_bub, e_pipe, n_mode, n_left, n_sd, n_cnt;
      stall = a_s; br = a_b; hi = a_hi; hr = a_hr; run = a_run; step = a_step;
      @(negedge clk);
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; e_pipe = 0;
      n_mode = m_mode; n_left = m_left; n_sd = 0; n_cnt = m_cnt;
      if (m_mode == M_RUN || m_mode == M_STEP) begin
         e_pipe = 1;
         e_pc   = (!a_s || a_b) ? 1 : 0;
         e_ifid = e_pc;
         e_fl   = a_b;
         e_bub  = a_s;
         if (a_s && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
         if (m_mode == M_STEP) begin
            n_mode = M_HALT; n_sd = 1;
         end else if (a_hi || a_hr) begin
            n_mode = M_DRAIN; n_left = D;
         end
      end else if (m_mode == M_DRAIN) begin
         e_pipe = 1; e_ifid = 1; e_fl = 1;
         n_left = m_left - 1;
         if (n_left == 0) n_mode = M_HALT;
      end else begin
         if (a_run) n_mode = M_RUN;
         else if (a_step) n_mode = M_STEP;
      end
      s_pc = int'(pc_we); s_ifid = int'(if_id_we); s_flush = int'(if_id_flush);
      s_bub = int'(id_ex_bubble); s_pipe = int'(pipe_we); s_halt = int'(halted);
      s_sd = int'(step_done); s_cnt = int'(stall_count);
      chk("pc_we", 32'(pc_we), 32'(e_pc));
      chk("if_id_we", 32'(if_id_we), 32'(e_ifid));
      chk("if_id_flush", 32'(if_id_flush), 32'(e_fl));
      chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
      chk("pipe_we", 32'(pipe_we), 32'(e_pipe));
      chk("halted", 32'(halted), (m_mode == M_HALT) ? 32'd1 : 32'd0);
      chk("step_done", 32'(step_done), 32'(m_sd));
      chk("stall_count", 32'(stall_count), CNT_EN ? 32'(m_cnt) : 32'd0);
      @(posedge clk);
      #1;
      m_mode = n_mode; m_left = n_left; m_sd = n_sd; m_cnt = n_cnt;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 0; br = 0; hi = 0; hr = 0; run = 0; step = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset state
      cycle(0,0,0,0,0,0);
      chk("lit_reset_halted", 32'(s_halt), 32'd1);
      chk("lit_reset_pc_we", 32'(s_pc), 32'd0);
      chk("lit_reset_step_done", 32'(s_sd), 32'd0);

      // Run from halt
      cycle(0,0,0,0,1,0);
      chk("lit_run_still_halted", 32'(s_halt), 32'd1);
      cycle(0,0,0,0,0,0);
      chk("lit_run_halted", 32'(s_halt), 32'd0);
      chk("lit_run_pc_we", 32'(s_pc), 32'd1);
      chk("lit_run_if_id_we", 32'(s_ifid), 32'd1);
      chk("lit_run_pipe_we", 32'(s_pipe), 32'd1);

      // Two stall cycles
      for (int i = 0; i < 2; i++) begin
         cycle(1,0,0,0,0,0);
         chk("lit_stall_pc_we", 32'(s_pc), 32'd0);
         chk("lit_stall_if_id_we", 32'(s_ifid), 32'd0);
         chk("lit_stall_bubble", 32'(s_bub), 32'd1);
      end
      cycle(0,0,0,0,0,0);
      chk("lit_stall_count", 32'(s_cnt), CNT_EN ? 32'd2 : 32'd0);

      // Stall and branch together
      cycle(1,1,0,0,0,0);
      chk("lit_sb_pc_we", 32'(s_pc), 32'd1);
      chk("lit_sb_flush", 32'(s_flush), 32'd1);
      chk("lit_sb_bubble", 32'(s_bub), 32'd1);

      // HALT instruction then drain
      cycle(0,0,1,0,0,0);
      chk("lit_hi_pc_we", 32'(s_pc), 32'd1);
      for (int i = 0; i < D; i++) begin
         cycle(1,1,0,0,0,0);
         chk("lit_drain_pipe_we", 32'(s_pipe), 32'd1);
         chk("lit_drain_pc_we", 32'(s_pc), 32'd0);
         chk("lit_drain_halted", 32'(s_halt), 32'd0);
      end
      cycle(0,0,0,0,0,0);
      chk("lit_drain_done_halted", 32'(s_halt), 32'd1);

      // Single step
      cycle(0,0,0,0,0,1);
      cycle(0,0,1,0,0,0);
      chk("lit_step_pc_we", 32'(s_pc), 32'd1);
      chk("lit_step_if_id_we", 32'(s_ifid), 32'd1);
      chk("lit_step_pipe_we", 32'(s_pipe), 32'd1);
      chk("lit_step_halted", 32'(s_halt), 32'd0);
      cycle(0,0,0,0,0,0);
      chk("lit_step_back_halted", 32'(s_halt), 32'd1);
      chk("lit_step_done", 32'(s_sd), 32'd1);
      cycle(0,0,0,0,0,0);
      chk("lit_step_done_clear", 32'(s_sd), 32'd0);

      // Run and step together: run wins
      cycle(0,0,0,0,1,1);
      cycle(1,0,0,0,0,0);
      cycle(0,0,0,0,0,0);
      chk("lit_runwins_halted", 32'(s_halt), 32'd0);

      // Asynchronous reset in the middle of a drain
      cycle(1,0,0,1,0,0);
      cycle(0,0,0,0,0,0);
      chk("lit_pre_rst_in_drain", 32'(s_pc), 32'd0);
      rst_n = 1'b0;
      #2;
      chk("lit_rst_halted", 32'(halted), 32'd1);
      chk("lit_rst_pc_we", 32'(pc_we), 32'd0);
      chk("lit_rst_pipe_we", 32'(pipe_we), 32'd0);
      chk("lit_rst_if_id_we", 32'(if_id_we), 32'd0);
      chk("lit_rst_count", 32'(stall_count), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(0,0,0,0,0,0);
      chk("lit_rst_stays_halted", 32'(s_halt), 32'd1);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
               $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
               $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
